dmem_arbiter: RTL

- Shares the single data-memory port between two load/store requesters: the scalar LS functional unit (port prefix s_) and the matrix/vector LS unit (port prefix v_).
- Round-robin grant; the address, store data and operation are latched at grant and held on the memory port until dhit_in.
- Sits between the LS functional units and the data cache/memory interface in the tensor-core datapath.

---
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the scalar (s_) and matrix/vector (v_) LS units.
// Optional watchdog: define DMEM_ARB_TIMEOUT_EN to abort a stalled transaction after TIMEOUT busy cycles.
module dmem_arbiter #(
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              s_ren,
    input  logic              s_wen,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [WORD_W-1:0] s_store,
    output logic              s_hit,
    output logic [WORD_W-1:0] s_load,
    input  logic              v_ren,
    input  logic              v_wen,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic [WORD_W-1:0] v_store,
    output logic              v_hit,
    output logic [WORD_W-1:0] v_load,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    input  logic              dhit_in,
    input  logic [WORD_W-1:0] dmem_in,
    output logic              arb_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic SIDE_S = 1'b0;
    localparam logic SIDE_V = 1'b1;

    state_t            r_state;
    logic              r_owner;
    logic              r_last;
    logic              r_op;
    logic              r_maskS;
    logic              r_maskV;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_store;
    logic              r_sHit;
    logic              r_vHit;
    logic [WORD_W-1:0] r_sLoad;
    logic [WORD_W-1:0] r_vLoad;

    logic w_busy;
    logic w_sReq;
    logic w_vReq;
    logic w_grant;
    logic w_grantV;
    logic w_end;

    // A side that just received its hit is masked for one cycle so a lingering request cannot re-issue.
    assign w_busy   = (r_state == BUSY);
    assign w_sReq   = (s_ren | s_wen) & ~r_maskS;
    assign w_vReq   = (v_ren | v_wen) & ~r_maskV;
    assign w_grant  = w_sReq | w_vReq;
    assign w_grantV = w_vReq & (~w_sReq | (r_last == SIDE_S));

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_timeout;

    assign w_timeout = w_busy & ~dhit_in & (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_end     = dhit_in | w_timeout;
    assign arb_err   = r_err;
`else
    // Keeps TIMEOUT referenced in the build without a watchdog; the result is constant zero.
    assign w_end   = dhit_in;
    assign arb_err = 1'b0 & (TIMEOUT > 0);
`endif

    assign dmemREN   = w_busy & ~r_op & ~w_end;
    assign dmemWEN   = w_busy &  r_op & ~w_end;
    assign dmemaddr  = w_busy ? r_addr  : '0;
    assign dmemstore = w_busy ? r_store : '0;

    assign s_hit  = r_sHit;
    assign s_load = r_sLoad;
    assign v_hit  = r_vHit;
    assign v_load = r_vLoad;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_owner <= SIDE_S;
            r_last  <= SIDE_V;
            r_op    <= 1'b0;
            r_maskS <= 1'b0;
            r_maskV <= 1'b0;
            r_addr  <= '0;
            r_store <= '0;
            r_sHit  <= 1'b0;
            r_vHit  <= 1'b0;
            r_sLoad <= '0;
            r_vLoad <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_sHit  <= 1'b0;
            r_vHit  <= 1'b0;
            r_sLoad <= '0;
            r_vLoad <= '0;
            r_maskS <= 1'b0;
            r_maskV <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_grantV;
                        r_addr  <= w_grantV ? v_addr  : s_addr;
                        r_store <= w_grantV ? v_store : s_store;
                        r_op    <= w_grantV ? v_wen   : s_wen;
                        r_state <= BUSY;
`ifdef DMEM_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (dhit_in) begin
                        if (r_owner == SIDE_V) begin
                            r_vHit  <= 1'b1;
                            r_vLoad <= r_op ? '0 : dmem_in;
                            r_maskV <= 1'b1;
                        end else begin
                            r_sHit  <= 1'b1;
                            r_sLoad <= r_op ? '0 : dmem_in;
                            r_maskS <= 1'b1;
                        end
                        r_last  <= r_owner;
                        r_state <= IDLE;
                    end
`ifdef DMEM_ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_sHit  <= (r_owner == SIDE_S);
                        r_vHit  <= (r_owner == SIDE_V);
                        r_last  <= r_owner;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
